// File: rtl/demux_1to4_fsm.sv
// demux_1to4_fsm: registered 1-to-4 demultiplexer sequenced by an IDLE/ROUTE/DONE(/WAIT) FSM
// Ports: clk, rst_n (async active-low); d/sel/i_vld request in, i_rdy = idle;
//        y0..y3 registered channel data; o_vld one-hot valid; o_ack per-channel ack.
// Build option DEMUX_ACK_EN: o_vld is held in WAIT until o_ack[sel_r], else o_vld is a 1-cycle pulse.
module demux_1to4_fsm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             i_vld,
    output logic             i_rdy,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       o_vld,
    input  logic [3:0]       o_ack
);
`ifdef DEMUX_ACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DONE = 2'd2, WAIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DONE = 2'd2} state_t;
`endif
    state_t           state, next;
    logic [WIDTH-1:0] d_r;
    logic [1:0]       sel_r;
    logic             take;
    assign i_rdy = (state == IDLE);
    assign take  = i_rdy && i_vld;
`ifdef DEMUX_ACK_EN
    // arm blocks the ack on the first WAIT cycle so o_vld is high for at least two cycles
    logic arm;
    logic release_ack;
    assign release_ack = arm && o_ack[sel_r];
    always_comb
        next = (state == IDLE)  ? (i_vld ? ROUTE : IDLE) :
               (state == ROUTE) ? DONE :
               (state == DONE)  ? WAIT :
                                  (release_ack ? IDLE : WAIT);
`else
    logic unused_ack;
    assign unused_ack = ^o_ack;
    always_comb
        next = (state == IDLE)  ? (i_vld ? ROUTE : IDLE) :
               (state == ROUTE) ? DONE :
                                  IDLE;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            d_r   <= '0;
            sel_r <= '0;
            y0    <= '0;
            y1    <= '0;
            y2    <= '0;
            y3    <= '0;
            o_vld <= '0;
`ifdef DEMUX_ACK_EN
            arm   <= 1'b0;
`endif
        end else begin
            if (take) begin
                d_r   <= d;
                sel_r <= sel;
            end
            if (state == ROUTE && sel_r == 2'd0) y0 <= d_r;
            if (state == ROUTE && sel_r == 2'd1) y1 <= d_r;
            if (state == ROUTE && sel_r == 2'd2) y2 <= d_r;
            if (state == ROUTE && sel_r == 2'd3) y3 <= d_r;
`ifdef DEMUX_ACK_EN
            arm   <= (state == WAIT);
            o_vld <= (state == DONE) ? 4'(4'b0001 << sel_r) :
                     (state == IDLE || (state == WAIT && release_ack)) ? 4'b0000 : o_vld;
`else
            o_vld <= (state == DONE) ? 4'(4'b0001 << sel_r) :
                     (state == IDLE) ? 4'b0000 : o_vld;
`endif
        end
endmodule
